// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee-machine coin sequencer.
package coffee_pkg;

    localparam int COIN_W = 4;
    localparam logic [COIN_W-1:0] PRICE_DEF = 4'd5;
    localparam logic [COIN_W-1:0] SUM_MAX = '1;
    localparam logic [15:0] TIMEOUT_CYC = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        SETTLE   = 3'd2,
        DISPENSE = 3'd3,
        PAY      = 3'd4,
        CLEAR    = 3'd5
    } state_t;

endpackage

// File: rtl/coffee_down_timer.sv
// Loadable down-counter that stops at zero; load wins over decrement.
module coffee_down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/coffee_seq_ctrl.sv
// Coin/cancel sequencer for the coffee datapath; all outputs registered (one cycle after the input).
// Optional COLLECT inactivity refund enabled by defining COFFEE_SEQ_TIMEOUT_EN.
module coffee_seq_ctrl
    import coffee_pkg::*;
#(
    parameter logic [COIN_W-1:0] PRICE      = PRICE_DEF,
    parameter int                DISP_CYC   = 8,
    parameter int                SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coin,
    input  logic              cancel,
    input  logic [COIN_W-1:0] sum,
    input  logic              eql_grt,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic              coin_rej,
    output logic              dispense,
    output logic              pay_vld,
    output logic [COIN_W-1:0] pay_amt,
    output logic              is_refund,
    output logic              busy
);

    state_t            state, state_d;
    logic              cnt_en_d, cnt_clr_d, coin_rej_d, dispense_d, pay_vld_d, is_refund_d;
    logic [COIN_W-1:0] pay_amt_d;
    logic              cancel_flag, cancel_flag_d;
    logic              settle_load, settle_zero, disp_load, disp_zero;
    logic              coin_ok, timeout_hit;

    // A saturated counter cannot take another coin, so it is handed back instead.
    assign coin_ok = coin && (sum != SUM_MAX);

    coffee_down_timer #(.W(8)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (settle_load),
        .dec      (state == SETTLE),
        .load_val (8'(SETTLE_CYC)),
        .zero     (settle_zero)
    );

    coffee_down_timer #(.W(8)) u_disp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (disp_load),
        .dec      (state == DISPENSE),
        .load_val (8'(DISP_CYC - 1)),
        .zero     (disp_zero)
    );

`ifdef COFFEE_SEQ_TIMEOUT_EN
    logic to_zero;

    coffee_down_timer #(.W(16)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != COLLECT),
        .dec      (state == COLLECT),
        .load_val (TIMEOUT_CYC),
        .zero     (to_zero)
    );

    assign timeout_hit = (state == COLLECT) && to_zero;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state;
        cancel_flag_d = cancel_flag;
        cnt_en_d      = 1'b0;
        cnt_clr_d     = 1'b0;
        coin_rej_d    = 1'b0;
        dispense_d    = 1'b0;
        pay_vld_d     = 1'b0;
        pay_amt_d     = '0;
        is_refund_d   = 1'b0;
        settle_load   = 1'b0;
        disp_load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (coin) begin
                    cnt_en_d    = 1'b1;
                    settle_load = 1'b1;
                    state_d     = SETTLE;
                end
            end
            COLLECT: begin
                if (coin_ok) begin
                    cnt_en_d      = 1'b1;
                    settle_load   = 1'b1;
                    cancel_flag_d = cancel;
                    state_d       = SETTLE;
                end else begin
                    coin_rej_d = coin;
                    if (cancel || timeout_hit) begin
                        pay_vld_d   = 1'b1;
                        pay_amt_d   = sum;
                        is_refund_d = 1'b1;
                        state_d     = PAY;
                    end
                end
            end
            SETTLE: begin
                if (cancel) cancel_flag_d = 1'b1;
                if (coin_ok) begin
                    cnt_en_d    = 1'b1;
                    settle_load = 1'b1;
                end else begin
                    coin_rej_d = coin;
                    if (settle_zero) begin
                        // A paid-up purchase beats a pending cancel.
                        if (eql_grt) begin
                            dispense_d = 1'b1;
                            disp_load  = 1'b1;
                            state_d    = DISPENSE;
                        end else if (cancel_flag || cancel) begin
                            pay_vld_d   = 1'b1;
                            pay_amt_d   = sum;
                            is_refund_d = 1'b1;
                            state_d     = PAY;
                        end else begin
                            state_d = COLLECT;
                        end
                        cancel_flag_d = 1'b0;
                    end
                end
            end
            DISPENSE: begin
                coin_rej_d = coin;
                if (disp_zero) begin
                    pay_vld_d = 1'b1;
                    pay_amt_d = sum - PRICE;
                    state_d   = PAY;
                end else begin
                    dispense_d = 1'b1;
                end
            end
            PAY: begin
                coin_rej_d = coin;
                cnt_clr_d  = 1'b1;
                state_d    = CLEAR;
            end
            CLEAR: begin
                coin_rej_d = coin;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cancel_flag <= 1'b0;
            cnt_en      <= 1'b0;
            cnt_clr     <= 1'b0;
            coin_rej    <= 1'b0;
            dispense    <= 1'b0;
            pay_vld     <= 1'b0;
            pay_amt     <= '0;
            is_refund   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            cancel_flag <= cancel_flag_d;
            cnt_en      <= cnt_en_d;
            cnt_clr     <= cnt_clr_d;
            coin_rej    <= coin_rej_d;
            dispense    <= dispense_d;
            pay_vld     <= pay_vld_d;
            pay_amt     <= pay_amt_d;
            is_refund   <= is_refund_d;
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_coffee_seq_ctrl.sv
// Session-level bench for coffee_seq_ctrl with a small datapath model (counter + registered comparator).
module tb_coffee_seq_ctrl;

    localparam logic [3:0] PRICE    = 4'd5;
    localparam int         DISP_CYC = 8;

    logic       clk = 1'b0;
    logic       rst_n, coin, cancel, eql_grt;
    logic [3:0] sum;
    logic       cnt_en, cnt_clr, coin_rej, dispense, pay_vld, is_refund, busy;
    logic [3:0] pay_amt;

    int tests = 0;
    int fails = 0;
    int n_en, n_clr, n_rej, n_disp, n_pay, n_both;
    logic [3:0] last_amt;
    logic       last_ref;

    coffee_seq_ctrl #(.PRICE(PRICE), .DISP_CYC(DISP_CYC), .SETTLE_CYC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coin      (coin),
        .cancel    (cancel),
        .sum       (sum),
        .eql_grt   (eql_grt),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .coin_rej  (coin_rej),
        .dispense  (dispense),
        .pay_vld   (pay_vld),
        .pay_amt   (pay_amt),
        .is_refund (is_refund),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Datapath: coin counter cleared by cnt_clr or reset, comparator registered one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= 4'd0;
            eql_grt <= 1'b0;
        end else begin
            if (cnt_clr)     sum <= 4'd0;
            else if (cnt_en) sum <= sum + 4'd1;
            eql_grt <= (sum >= PRICE);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (cnt_en)             n_en++;
            if (cnt_clr)            n_clr++;
            if (coin_rej)           n_rej++;
            if (dispense)           n_disp++;
            if (cnt_en && cnt_clr)  n_both++;
            if (pay_vld) begin
                n_pay++;
                last_amt = pay_amt;
                last_ref = is_refund;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_en = 0; n_clr = 0; n_rej = 0; n_disp = 0; n_pay = 0; n_both = 0;
        last_amt = 4'd0; last_ref = 1'b0;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic c, input logic x);
        coin   = c;
        cancel = x;
        @(posedge clk);
        #1;
        coin   = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy !== 1'b0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("idle_reached", {31'd0, busy}, 0);
        @(posedge clk);
        #1;
    endtask

    // One customer session: a burst of n coins spaced g cycles, then either a paid
    // purchase (with n_dr coins during dispense), a cancel (mode 0), or top-up coins
    // with a cancel riding on coin jsel (mode 1) or no cancel (mode 2).
    task automatic session(input int n, input int g, input int n_dr, input int mode, input int jsel);
        int counted, rej, exp_disp, exp_amt, exp_ref, k, j;
        clear_mon();
        counted = (g == 2 && n > 15) ? 15 : n;
        rej     = n - counted;
        for (int i = 0; i < n; i++) begin
            pulse(1'b1, 1'b0);
            if (i < n - 1) idle(g - 1);
        end
        idle(3);
        if (counted >= 5) begin
            for (int i = 0; i < n_dr; i++) pulse(1'b1, 1'b0);
            rej      += n_dr;
            exp_disp = DISP_CYC;
            exp_amt  = counted - 5;
            exp_ref  = 0;
        end else begin
            k        = 5 - counted;
            exp_disp = 0;
            exp_ref  = 1;
            if (mode == 0) begin
                pulse(1'b0, 1'b1);
            end else begin
                j = (mode == 1) ? (jsel % k) : k;
                for (int i = 0; i < k; i++) begin
                    pulse(1'b1, i == j);
                    counted++;
                    if (i == j) break;
                    idle(3);
                end
                if (counted >= 5) begin
                    exp_disp = DISP_CYC;
                    exp_ref  = 0;
                end
            end
            exp_amt = (counted >= 5) ? 0 : counted;
        end
        wait_idle();
        chk("cnt_en_pulses",   n_en,   counted);
        chk("coin_rej_pulses", n_rej,  rej);
        chk("dispense_cycles", n_disp, exp_disp);
        chk("pay_pulses",      n_pay,  1);
        chk("pay_amt",         {28'd0, last_amt}, exp_amt);
        chk("is_refund",       {31'd0, last_ref}, exp_ref);
        chk("cnt_clr_pulses",  n_clr,  1);
        chk("en_clr_overlap",  n_both, 0);
        chk("sum_cleared",     {28'd0, sum}, 0);
    endtask

    initial begin
        int c;
        rst_n  = 1'b0;
        coin   = 1'b0;
        cancel = 1'b0;
        clear_mon();
        #22;
        chk("reset_outputs", {cnt_en, cnt_clr, coin_rej, dispense, pay_vld, pay_amt, is_refund, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {cnt_en, cnt_clr, coin_rej, dispense, pay_vld, pay_amt, is_refund, busy}, 0);
        @(posedge clk);
        #1;

        session(5, 4, 0, 2, 0);    // five spaced coins: exact price
        session(7, 1, 0, 2, 0);    // back-to-back: change of 2
        session(3, 1, 0, 0, 0);    // cancel in COLLECT: refund 3
        session(6, 1, 2, 2, 0);    // coins during dispense are rejected
        session(17, 2, 0, 2, 0);   // saturation: two coins rejected at sum 15
        session(3, 1, 0, 1, 1);    // cancel together with the fifth coin completes
        session(2, 4, 0, 1, 0);    // sticky cancel before price reached: refund

        for (int s = 0; s < 14; s++) begin
            int g, n;
            case ($urandom_range(0, 2))
                0:       g = 1;
                1:       g = 2;
                default: g = 4;
            endcase
            n = (g == 1) ? int'($urandom_range(1, 14)) :
                (g == 2) ? int'($urandom_range(1, 17)) : int'($urandom_range(1, 5));
            session(n, g, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 7)));
        end

        // Reset in the middle of dispensing.
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        c = 0;
        while (dispense !== 1'b1 && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("dispense_started", {31'd0, dispense}, 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_dispense_drop", {31'd0, dispense}, 0);
        chk("async_outputs_zero", {cnt_en, cnt_clr, coin_rej, dispense, pay_vld, pay_amt, is_refund, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        @(posedge clk);
        #1;
        pulse(1'b1, 1'b0);
        @(negedge clk);
        chk("first_coin_cnt_en", {31'd0, cnt_en}, 1);
        chk("first_coin_busy",   {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        idle(2);
        pulse(1'b0, 1'b1);
        wait_idle();
        chk("after_reset_refund_amt", {28'd0, last_amt}, 1);
        chk("after_reset_is_refund",  {31'd0, last_ref}, 1);
        chk("after_reset_dispense",   n_disp, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
